wave_scale_ctrl: RTL and testbench
==================================

WAVE_SCALE_CTRL -- requirements
Module: wave_scale_ctrl

Interface
REQ-001 SHALL have parameter XSCALE_RESET, default 3'd0, meaning the value loaded into the xscale shadow and output at reset.
REQ-002 SHALL have parameter YSCALE_RESET, default 3'd0, meaning the value loaded into the yscale shadow and output at reset.
REQ-003 SHALL have parameter REPEAT_DELAY, default 25000000, meaning the number of held cycles from press to the first auto-repeat step; legal range >=2.
REQ-004 SHALL have parameter REPEAT_RATE, default 5000000, meaning the number of cycles between later auto-repeat steps; legal range >=2.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 btn_xup, btn_xdn, btn_yup, btn_ydn  input  1 each  debounced button levels (1 = held).
REQ-008 vsync  input  1  display vsync; 0 = wave display idle (blanking).
REQ-009 xscale  output  3  committed horizontal scale for the address scaler.
REQ-010 yscale  output  3  committed vertical scale for the sample scaler.
REQ-011 pending  output  1  high when either shadow differs from its committed output.

Function
REQ-012 SHALL keep two independent axis channels, X (btn_xup/btn_xdn, shadow sx) and Y (btn_yup/btn_ydn, shadow sy), with identical behaviour.
REQ-013 SHALL run a per-axis state machine with states IDLE, DELAY and REPEAT, plus a per-axis down-counter wide enough for max(REPEAT_DELAY, REPEAT_RATE).
REQ-014 Condition "active" for an axis SHALL mean exactly one of its two buttons is 1; both or neither SHALL count as inactive.
REQ-015 IDLE to DELAY: on the first cycle the axis is active (cycle t0), issue one step and load the counter with REPEAT_DELAY-1.
REQ-016 DELAY to REPEAT: while active, decrement each cycle; when the counter reads 0 (cycle t0+REPEAT_DELAY), issue one step and load REPEAT_RATE-1.
REQ-017 In REPEAT, while active, issue one step and reload REPEAT_RATE-1 each time the counter reads 0, giving steps at t0+REPEAT_DELAY+k*REPEAT_RATE.
REQ-018 Any cycle the axis is inactive SHALL force IDLE and issue no step; a direction change with no inactive cycle in between SHALL NOT restart the sequence.
REQ-019 A step SHALL add 1 to the shadow for the up button and subtract 1 for the down button, saturating at 7 and 0; the shadow updates on the edge closing the step cycle.
REQ-020 Commit event: vsync sampled 0 while the registered previous vsync is 1; on that edge xscale<=sx and yscale<=sy (pre-step values in that cycle).
REQ-021 A step and a commit in the same cycle: the outputs take the old shadow, the shadow takes the stepped value, and pending is 1 the next cycle.
REQ-022 xscale and yscale SHALL change only on commit edges, never while vsync is 1, and at most once per frame.
REQ-023 pending SHALL be combinational: (sx!=xscale)|(sy!=yscale).
REQ-024 vsync is synchronous to clk; no synchronizer is required.

Reset
REQ-025 On reset, xscale, sx <= XSCALE_RESET; yscale, sy <= YSCALE_RESET; both FSMs <= IDLE; counters <= 0; previous vsync <= 0; pending therefore reads 0.
REQ-026 Reset SHALL override all buttons and commits in the same cycle; a button held through reset SHALL be treated as a new press on the first cycle after reset.
REQ-027 Because previous vsync resets to 0, no commit SHALL occur in the first cycle after reset, even with vsync=0.

Verification (bench: REPEAT_DELAY=8, REPEAT_RATE=4, resets 0)
REQ-028 Pulse btn_xup 1 cycle with vsync=1 -> sx=1, pending=1, xscale stays 0; drop vsync -> xscale=1 on that edge, pending=0.
REQ-029 Hold btn_yup 20 cycles from t0 -> steps at t0, t0+8, t0+12, t0+16, so sy=4; after 30 cycles of holding, sy saturates at 7 with no wrap.
REQ-030 Hold btn_xup and btn_xdn together 20 cycles -> sx unchanged and no step; release btn_xdn -> new press, sx+1 on that cycle.
REQ-031 Step coincident with the vsync falling edge (sx 2->3) -> xscale=2 and pending=1; next falling edge -> xscale=3.
REQ-032 Assert reset mid-REPEAT with xscale=5 and btn_xup held -> xscale=0 after reset; first post-reset cycle steps sx to 1; holding vsync=0 produces no commit until a 1->0 transition.
REQ-033 Pulse btn_xdn at sx=0 -> sx stays 0 and pending stays 0.

Source files
------------

// File: rtl/wave_scale_ctrl.sv
// Two-axis button scale controller with press/auto-repeat stepping.
// Shadow scales commit to the outputs on the vsync falling edge so the display never sees a mid-frame change.
module wave_scale_ctrl #(
  parameter logic [2:0] XSCALE_RESET = 3'd0,
  parameter logic [2:0] YSCALE_RESET = 3'd0,
  parameter int         REPEAT_DELAY = 25000000,
  parameter int         REPEAT_RATE  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_xup,
  input  logic       btn_xdn,
  input  logic       btn_yup,
  input  logic       btn_ydn,
  input  logic       vsync,
  output logic [2:0] xscale,
  output logic [2:0] yscale,
  output logic       pending
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} axis_state_e;

  // Index 0 is the X axis, index 1 is the Y axis.
  logic [1:0]       btn_up, btn_dn, active, step;
  axis_state_e      state_q [2];
  axis_state_e      state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [2:0]       shadow_q[2];
  logic [2:0]       shadow_d[2];
  logic [2:0]       scale_q [2];
  logic             vsync_q;
  logic             commit;

  assign btn_up = {btn_yup, btn_xup};
  assign btn_dn = {btn_ydn, btn_xdn};
  assign active = btn_up ^ btn_dn;
  assign commit = vsync_q & ~vsync;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    step = '0;
    for (int a = 0; a < 2; a++) begin
      state_d[a]  = state_q[a];
      cnt_d[a]    = cnt_q[a];
      shadow_d[a] = shadow_q[a];
      if (!active[a]) begin
        state_d[a] = IDLE;
      end else begin
        unique case (state_q[a])
          IDLE: begin
            step[a]    = 1'b1;
            state_d[a] = DELAY;
            cnt_d[a]   = DELAY_LOAD;
          end
          DELAY, REPEAT: begin
            if (cnt_q[a] == '0) begin
              step[a]    = 1'b1;
              state_d[a] = REPEAT;
              cnt_d[a]   = RATE_LOAD;
            end else begin
              cnt_d[a] = cnt_q[a] - CNT_W'(1);
            end
          end
          default: state_d[a] = IDLE;
        endcase
      end
      // The pressed button decides direction at the step, so a direct up/down swap keeps the cadence.
      if (step[a]) begin
        if (btn_up[a]) shadow_d[a] = (shadow_q[a] == 3'd7) ? 3'd7 : shadow_q[a] + 3'd1;
        else           shadow_d[a] = (shadow_q[a] == 3'd0) ? 3'd0 : shadow_q[a] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      for (int a = 0; a < 2; a++) begin
        state_q[a] <= IDLE;
        cnt_q[a]   <= '0;
      end
      shadow_q[0] <= XSCALE_RESET;
      shadow_q[1] <= YSCALE_RESET;
      scale_q[0]  <= XSCALE_RESET;
      scale_q[1]  <= YSCALE_RESET;
      vsync_q     <= 1'b0;
    end else begin
      for (int a = 0; a < 2; a++) begin
        state_q[a]  <= state_d[a];
        cnt_q[a]    <= cnt_d[a];
        shadow_q[a] <= shadow_d[a];
        if (commit) scale_q[a] <= shadow_q[a];
      end
      vsync_q <= vsync;
    end
  end

  assign xscale  = scale_q[0];
  assign yscale  = scale_q[1];
  assign pending = (shadow_q[0] != scale_q[0]) | (shadow_q[1] != scale_q[1]);

endmodule

// File: tb/tb_wave_scale_ctrl.sv
// Bench for wave_scale_ctrl: directed scenarios plus random buttons/vsync against a run-length reference model.
module tb_wave_scale_ctrl;
  localparam int D = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_xup = 1'b0, btn_xdn = 1'b0, btn_yup = 1'b0, btn_ydn = 1'b0;
  logic       vsync = 1'b1;
  logic [2:0] xscale, yscale;
  logic       pending;

  int checks = 0;
  int errors = 0;

  // Reference: consecutive active cycles seen so far, shadow, committed scale, previous vsync.
  int run[2];
  int sh[2];
  int outv[2];
  bit pv;

  wave_scale_ctrl #(
    .XSCALE_RESET(3'd0), .YSCALE_RESET(3'd0),
    .REPEAT_DELAY(D), .REPEAT_RATE(R)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_xup(btn_xup), .btn_xdn(btn_xdn), .btn_yup(btn_yup), .btn_ydn(btn_ydn),
    .vsync(vsync), .xscale(xscale), .yscale(yscale), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic model_step();
    bit up[2], dn[2];
    up[0] = btn_xup; dn[0] = btn_xdn; up[1] = btn_yup; dn[1] = btn_ydn;
    if (reset) begin
      for (int a = 0; a < 2; a++) begin
        run[a] = 0; sh[a] = 0; outv[a] = 0;
      end
      pv = 1'b0;
    end else begin
      if (pv && !vsync) for (int a = 0; a < 2; a++) outv[a] = sh[a];
      for (int a = 0; a < 2; a++) begin
        if (up[a] != dn[a]) begin
          if (run[a] == 0 || (run[a] >= D && (run[a] - D) % R == 0)) begin
            if (up[a]) sh[a] = (sh[a] < 7) ? sh[a] + 1 : 7;
            else       sh[a] = (sh[a] > 0) ? sh[a] - 1 : 0;
          end
          run[a]++;
        end else begin
          run[a] = 0;
        end
      end
      pv = vsync;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("xscale", 32'(xscale), 32'(outv[0]));
    check("yscale", 32'(yscale), 32'(outv[1]));
    check("pending", 32'(pending), 32'((sh[0] != outv[0]) || (sh[1] != outv[1])));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btn(input bit xu, input bit xd, input bit yu, input bit yd);
    btn_xup = xu; btn_xdn = xd; btn_yup = yu; btn_ydn = yd;
  endtask

  task automatic do_reset();
    set_btn(0, 0, 0, 0);
    vsync = 1'b1;
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_xup(input int n);
    for (int i = 0; i < n; i++) begin
      set_btn(1, 0, 0, 0); tick();
      set_btn(0, 0, 0, 0); tick();
    end
  endtask

  initial begin
    // Reset state and single-pulse commit.
    do_reset();
    check("rst_xscale", 32'(xscale), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    set_btn(1, 0, 0, 0); tick();
    check("pulse_pending", 32'(pending), 32'd1);
    check("pulse_xscale_held", 32'(xscale), 32'd0);
    set_btn(0, 0, 0, 0); vsync = 1'b0; tick();
    check("pulse_commit", 32'(xscale), 32'd1);
    check("pulse_commit_pending", 32'(pending), 32'd0);
    vsync = 1'b1; tick();

    // Auto-repeat timing and saturation on Y.
    do_reset();
    set_btn(0, 0, 1, 0); ticks(20);
    set_btn(0, 0, 0, 0); vsync = 1'b0; tick();
    check("repeat_yscale4", 32'(yscale), 32'd4);
    vsync = 1'b1; tick();
    set_btn(0, 0, 1, 0); ticks(30);
    set_btn(0, 0, 0, 0); vsync = 1'b0; tick();
    check("repeat_yscale_sat", 32'(yscale), 32'd7);
    vsync = 1'b1; tick();

    // Both buttons held counts as inactive; releasing one is a new press.
    do_reset();
    set_btn(1, 1, 0, 0); ticks(20);
    check("both_no_step", 32'(pending), 32'd0);
    set_btn(1, 0, 0, 0); tick();
    check("release_press", 32'(pending), 32'd1);
    set_btn(0, 0, 0, 0); vsync = 1'b0; tick();
    check("release_commit", 32'(xscale), 32'd1);
    vsync = 1'b1; tick();

    // Step coincident with the commit edge.
    do_reset();
    pulse_xup(2);
    vsync = 1'b0; tick();
    vsync = 1'b1; tick();
    set_btn(1, 0, 0, 0); vsync = 1'b0; tick();
    check("coinc_xscale", 32'(xscale), 32'd2);
    check("coinc_pending", 32'(pending), 32'd1);
    set_btn(0, 0, 0, 0); vsync = 1'b1; tick();
    vsync = 1'b0; tick();
    check("coinc_next", 32'(xscale), 32'd3);
    vsync = 1'b1; tick();

    // Reset mid-repeat with the button held through it.
    do_reset();
    pulse_xup(5);
    vsync = 1'b0; tick();
    check("pre_rst_xscale", 32'(xscale), 32'd5);
    vsync = 1'b1; tick();
    set_btn(1, 0, 0, 0); ticks(12);
    vsync = 1'b0; reset = 1'b1; tick();
    check("mid_rst_xscale", 32'(xscale), 32'd0);
    reset = 1'b0; tick();
    check("post_rst_pending", 32'(pending), 32'd1);
    ticks(5);
    check("post_rst_no_commit", 32'(xscale), 32'd0);
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
    check("post_rst_commit", 32'(xscale), 32'd1);
    set_btn(0, 0, 0, 0); vsync = 1'b1; tick();

    // Down at zero saturates.
    do_reset();
    set_btn(0, 1, 0, 0); tick();
    set_btn(0, 0, 0, 0); tick();
    check("dn_at_zero", 32'(pending), 32'd0);

    // Random buttons and vsync, with rare resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) btn_xup = ~btn_xup;
      if ($urandom_range(0, 7) == 0) btn_xdn = ~btn_xdn;
      if ($urandom_range(0, 7) == 0) btn_yup = ~btn_yup;
      if ($urandom_range(0, 7) == 0) btn_ydn = ~btn_ydn;
      if ($urandom_range(0, 9) == 0) vsync = ~vsync;
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
